// File: rtl/io_out_buf_if.sv
// Core-write / peripheral-read bus of the output IO buffer.
// The slave modport is the buffer's view; the master modport is the core/peripheral side.
interface io_out_buf_if #(
   parameter int NUBITS = 32,
   parameter int NUIOOU = 8
);
   localparam int AW = $clog2(NUIOOU);

   logic              out_en;
   logic [AW-1:0]     addr_out;
   logic [NUBITS-1:0] data_out;
   logic              per_valid;
   logic [AW-1:0]     per_addr;
   logic [NUBITS-1:0] per_data;
   logic              per_ready;

   modport slave (
      input  out_en, addr_out, data_out, per_ready,
      output per_valid, per_addr, per_data
   );

   modport master (
      output out_en, addr_out, data_out, per_ready,
      input  per_valid, per_addr, per_data
   );
endinterface

// File: rtl/io_out_buf.sv
// FIFO buffering core output-IO writes {addr, data} toward a valid/ready peripheral port.
// Define IO_OUT_BUF_OVF_CNT_EN to add the saturating 8-bit dropped-write counter ovf_cnt.
module io_out_buf #(
   parameter int NUBITS = 32,
   parameter int NUIOOU = 8,
   parameter int FDEPTH = 8,
   localparam int AW = $clog2(NUIOOU),
   localparam int CW = $clog2(FDEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst,
   io_out_buf_if.slave   bus,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count,
   output logic          ovf,
   input  logic          ovf_clr
`ifdef IO_OUT_BUF_OVF_CNT_EN
   ,
   output logic [7:0]    ovf_cnt
`endif
);
   localparam int PW = $clog2(FDEPTH);
   localparam int EW = AW + NUBITS;

   logic [EW-1:0] mem [FDEPTH];
   logic [PW-1:0] wr_ptr_reg;
   logic [PW-1:0] rd_ptr_reg;
   logic [PW-1:0] rd_ptr_next;
   logic [CW-1:0] count_reg;
   logic [CW-1:0] count_next;
   logic [EW-1:0] head_reg;
   logic [EW-1:0] head_next;
   logic          ovf_reg;
   logic          push;
   logic          pop;
   logic          drop;

   // full is taken from the registered count, so a pop never frees room for a same-cycle write
   assign full  = (count_reg == CW'(FDEPTH));
   assign empty = (count_reg == '0);
   assign count = count_reg;
   assign ovf   = ovf_reg;

   assign push = bus.out_en && !full;
   assign drop = bus.out_en && full;
   assign pop  = !empty && bus.per_ready;

   assign bus.per_valid = !empty;
   assign bus.per_addr  = head_reg[EW-1:NUBITS];
   assign bus.per_data  = head_reg[NUBITS-1:0];

   always_comb begin
      rd_ptr_next = rd_ptr_reg;
      if (pop) begin
         rd_ptr_next = rd_ptr_reg + PW'(1);
      end
   end

   // Head register prefetches the entry the read pointer will point at next edge;
   // when that slot is being written this very edge, take the incoming entry instead.
   always_comb begin
      head_next = mem[rd_ptr_next];
      if (push && (wr_ptr_reg == rd_ptr_next)) begin
         head_next = {bus.addr_out, bus.data_out};
      end
   end

   always_comb begin
      count_next = count_reg;
      case ({push, pop})
         2'b10:   count_next = count_reg + CW'(1);
         2'b01:   count_next = count_reg - CW'(1);
         default: count_next = count_reg;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_reg] <= {bus.addr_out, bus.data_out};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
         head_reg   <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + PW'(1);
         end
         rd_ptr_reg <= rd_ptr_next;
         count_reg  <= count_next;
         head_reg   <= head_next;
      end
   end

   // A drop in the same cycle as a clear leaves the flag set
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_reg <= 1'b0;
      end else if (drop) begin
         ovf_reg <= 1'b1;
      end else if (ovf_clr) begin
         ovf_reg <= 1'b0;
      end
   end

`ifdef IO_OUT_BUF_OVF_CNT_EN
   logic [7:0] ovf_cnt_reg;

   assign ovf_cnt = ovf_cnt_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_cnt_reg <= '0;
      end else if (drop) begin
         if (ovf_clr) begin
            ovf_cnt_reg <= 8'd1;
         end else if (ovf_cnt_reg != 8'hFF) begin
            ovf_cnt_reg <= ovf_cnt_reg + 8'd1;
         end
      end else if (ovf_clr) begin
         ovf_cnt_reg <= '0;
      end
   end
`endif
endmodule

// File: tb/tb_io_out_buf.sv
// Randomized and directed bench for io_out_buf against a queue-based reference model.
module tb_io_out_buf;
   localparam int NUBITS = 32;
   localparam int NUIOOU = 8;
   localparam int FDEPTH = 8;
   localparam int AW     = 3;
   localparam int CW     = 4;
   localparam int EW     = AW + NUBITS;

   logic          clk = 1'b0;
   logic          rst;
   logic          full;
   logic          empty;
   logic [CW-1:0] count;
   logic          ovf;
   logic          ovf_clr;
`ifdef IO_OUT_BUF_OVF_CNT_EN
   logic [7:0]    ovf_cnt;
`endif
   logic [EW-1:0] head;

   io_out_buf_if #(.NUBITS(NUBITS), .NUIOOU(NUIOOU)) bus ();

   io_out_buf #(.NUBITS(NUBITS), .NUIOOU(NUIOOU), .FDEPTH(FDEPTH)) dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus),
      .full    (full),
      .empty   (empty),
      .count   (count),
      .ovf     (ovf),
      .ovf_clr (ovf_clr)
`ifdef IO_OUT_BUF_OVF_CNT_EN
      ,
      .ovf_cnt (ovf_cnt)
`endif
   );

   always #5 clk = ~clk;
   assign head = {bus.per_addr, bus.per_data};

   int            n_cmp = 0;
   int            n_err = 0;
   logic [EW-1:0] q[$];
   bit            m_ovf;
   int            m_ovf_cnt;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_outputs();
      check("per_valid", 64'(bus.per_valid), 64'(q.size() != 0));
      check("count", 64'(count), 64'(q.size()));
      check("empty", 64'(empty), 64'(q.size() == 0));
      check("full", 64'(full), 64'(q.size() == FDEPTH));
      check("ovf", 64'(ovf), 64'(m_ovf));
`ifdef IO_OUT_BUF_OVF_CNT_EN
      check("ovf_cnt", 64'(ovf_cnt), 64'(m_ovf_cnt));
`endif
      if (q.size() != 0) check("head", 64'(head), 64'(q[0]));
   endtask

   // One clock: apply inputs after a falling edge, update the model at the rising edge,
   // then compare at the next falling edge.
   task automatic cycle(input bit en, input logic [AW-1:0] a, input logic [NUBITS-1:0] d,
                        input bit rdy, input bit clr);
      bit was_full;
      bit pu;
      bit po;
      bit dr;
      logic [EW-1:0] popped;
      bus.out_en   = en;
      bus.addr_out = a;
      bus.data_out = d;
      bus.per_ready = rdy;
      ovf_clr      = clr;
      @(posedge clk);
      was_full = (q.size() == FDEPTH);
      pu = en && !was_full;
      po = (q.size() != 0) && rdy;
      dr = en && was_full;
      if (po) begin
         popped = q.pop_front();
         $display("%0t pop  a=%0d d=%08h", $time, popped[EW-1:NUBITS], popped[NUBITS-1:0]);
      end
      if (pu) begin
         q.push_back({a, d});
         $display("%0t push a=%0d d=%08h", $time, a, d);
      end
      if (dr) begin
         m_ovf = 1'b1;
         m_ovf_cnt = clr ? 1 : ((m_ovf_cnt < 255) ? m_ovf_cnt + 1 : 255);
         $display("%0t drop a=%0d d=%08h", $time, a, d);
      end else if (clr) begin
         m_ovf = 1'b0;
         m_ovf_cnt = 0;
      end
      @(negedge clk);
      check_outputs();
   endtask

   task automatic do_reset();
      bus.out_en    = 1'b0;
      bus.per_ready = 1'b0;
      ovf_clr       = 1'b0;
      #2 rst = 1'b1;
      #1;
      q.delete();
      m_ovf     = 1'b0;
      m_ovf_cnt = 0;
      check_outputs();
      check("rst_addr", 64'(bus.per_addr), 64'(0));
      check("rst_data", 64'(bus.per_data), 64'(0));
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      $display("%0t reset", $time);
   endtask

   task automatic drain();
      for (int i = 0; i < 4 * FDEPTH && q.size() != 0; i++) cycle(1'b0, '0, '0, 1'b1, 1'b0);
      check("drained", 64'(empty), 64'(1));
   endtask

   initial begin
      logic [EW-1:0] sent[$];
      logic [EW-1:0] got[$];
      logic [EW-1:0] held;
      logic [AW-1:0] a;
      logic [NUBITS-1:0] d;
      bit hold;
      bit en;
      bit rdy;
      int writes;
      int bias;

      rst = 1'b0;
      bus.out_en = 1'b0;
      bus.addr_out = '0;
      bus.data_out = '0;
      bus.per_ready = 1'b0;
      ovf_clr = 1'b0;
      m_ovf = 1'b0;
      m_ovf_cnt = 0;
      @(negedge clk);
      do_reset();

      // Single write becomes visible one cycle later
      cycle(1'b1, 3'd3, 32'h12345678, 1'b0, 1'b0);
      check("r33_valid", 64'(bus.per_valid), 64'(1));
      check("r33_addr", 64'(bus.per_addr), 64'(3));
      check("r33_data", 64'(bus.per_data), 64'h12345678);
      check("r33_count", 64'(count), 64'(1));

      // Fill, overflow by one, drain
      do_reset();
      for (int i = 1; i <= 8; i++) cycle(1'b1, AW'(i), NUBITS'(i), 1'b0, 1'b0);
      cycle(1'b1, 3'd1, 32'd9, 1'b0, 1'b0);
      check("r34_full", 64'(full), 64'(1));
      check("r34_count", 64'(count), 64'(8));
      check("r34_ovf", 64'(ovf), 64'(1));
`ifdef IO_OUT_BUF_OVF_CNT_EN
      check("r34_ovf_cnt", 64'(ovf_cnt), 64'(1));
`endif
      for (int i = 1; i <= 8; i++) begin
         check("r34_drain", 64'(bus.per_data), 64'(i));
         cycle(1'b0, '0, '0, 1'b1, 1'b0);
      end
      check("r34_empty", 64'(empty), 64'(1));

      // Steady push+pop at count 4 across pointer wrap
      do_reset();
      for (int i = 0; i < 4; i++) cycle(1'b1, AW'($urandom), $urandom, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) cycle(1'b1, AW'($urandom), $urandom, 1'b1, 1'b0);
      check("r35_count", 64'(count), 64'(4));
      drain();

      // Toggling ready against a 20-write stream that respects back-pressure
      do_reset();
      writes = 0;
      hold = 1'b0;
      held = '0;
      for (int c = 0; c < 200 && (writes < 20 || q.size() != 0); c++) begin
         rdy = (c % 2) == 0;
         if (hold) check("r36_stable", 64'(head), 64'(held));
         if (bus.per_valid && rdy) got.push_back(head);
         hold = bus.per_valid && !rdy;
         held = head;
         en = (writes < 20) && (q.size() < FDEPTH);
         a = AW'($urandom);
         d = $urandom;
         if (en) begin
            sent.push_back({a, d});
            writes++;
         end
         cycle(en, a, d, rdy, 1'b0);
      end
      check("r36_n", 64'(got.size()), 64'(20));
      for (int i = 0; i < 20 && i < got.size(); i++) check("r36_order", 64'(got[i]), 64'(sent[i]));

      // Full + write + pop + clear in one cycle: write dropped, flag stays
      do_reset();
      for (int i = 0; i < 8; i++) cycle(1'b1, AW'(i), NUBITS'(100 + i), 1'b0, 1'b0);
      cycle(1'b1, 3'd7, 32'd77, 1'b1, 1'b1);
      check("r37_count", 64'(count), 64'(7));
      check("r37_ovf", 64'(ovf), 64'(1));
      cycle(1'b0, '0, '0, 1'b0, 1'b1);
      check("r37_clr", 64'(ovf), 64'(0));

      // Reset mid-stream, then a fresh write
      for (int i = 0; i < 5; i++) cycle(1'b1, AW'(i), $urandom, 1'b0, 1'b0);
      do_reset();
      cycle(1'b1, 3'd2, 32'hAA, 1'b0, 1'b0);
      check("r38_data", 64'(bus.per_data), 64'hAA);
      check("r38_count", 64'(count), 64'(1));

      // Random traffic with drifting ready bias so the FIFO also hits full and empty
      bias = 50;
      for (int c = 0; c < 600; c++) begin
         if ((c % 50) == 0) bias = $urandom_range(10, 90);
         if ($urandom_range(0, 199) == 0) do_reset();
         cycle($urandom_range(0, 3) != 0, AW'($urandom), $urandom,
               $urandom_range(0, 99) < bias, $urandom_range(0, 15) == 0);
      end
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/io_out_buf.md
IO_OUT_BUF -- requirements
Module: io_out_buf

Interface
REQ-001 Parameter NUBITS, default 32: data width of core output writes.
REQ-002 Parameter NUIOOU, default 8: number of output IO addresses; address width AW = $clog2(NUIOOU).
REQ-003 Parameter FDEPTH, default 8: FIFO entries, power of two, >= 2; CW = $clog2(FDEPTH)+1.
REQ-004 clk  input  1  clock; all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 out_en  input  1  core output-write strobe, one write per cycle high.
REQ-007 addr_out  input  AW  core output IO address, qualified by out_en.
REQ-008 data_out  input  NUBITS  core output data, qualified by out_en.
REQ-009 per_valid  output  1  head entry available to peripheral side.
REQ-010 per_addr  output  AW  head entry address.
REQ-011 per_data  output  NUBITS  head entry data.
REQ-012 per_ready  input  1  peripheral accepts head entry when per_valid high.
REQ-013 full  output  1  count == FDEPTH.
REQ-014 empty  output  1  count == 0.
REQ-015 count  output  CW  entries stored.
REQ-016 ovf  output  1  sticky: at least one core write dropped.
REQ-017 ovf_clr  input  1  synchronous clear of ovf (and ovf_cnt when present).

Function
REQ-018 Push = out_en && !full; pushed entry {addr_out, data_out} stored at write pointer, pointer advances mod FDEPTH.
REQ-019 Pop = per_valid && per_ready; read pointer advances mod FDEPTH.
REQ-020 per_valid SHALL equal !empty; per_addr/per_data SHALL show entry at read pointer, stable while per_valid && !per_ready.
REQ-021 Latency: write accepted at edge N into empty FIFO SHALL give per_valid high after edge N, i.e. one cycle.
REQ-022 count SHALL increment on push-only, decrement on pop-only, hold on both or neither.
REQ-023 Push and pop in same cycle with 0 < count < FDEPTH: both occur, count unchanged, order preserved.
REQ-024 out_en while full: write dropped, FIFO unchanged, ovf set, even if pop occurs same cycle (full uses registered count).
REQ-025 out_en while empty: no pop possible that cycle; entry not bypassed to outputs combinationally.
REQ-026 per_ready while empty: ignored, no pointer or count change.
REQ-027 ovf set and ovf_clr in same cycle: set wins, ovf stays 1.
REQ-028 Entries SHALL leave in exact arrival order; no address-based reordering or merging.

Reset
REQ-029 rst high: pointers 0, count 0, empty 1, full 0, per_valid 0, ovf 0, ovf_cnt 0; per_addr/per_data SHALL be 0.
REQ-030 rst asserted mid-transfer discards all stored entries; first write after rst release starts at pointer 0.

Configuration
REQ-031 Macro IO_OUT_BUF_OVF_CNT_EN defined: extra output ovf_cnt (8 bits) counts dropped writes, saturates at 255, cleared by ovf_clr; increment wins over clear in same cycle (result 1).
REQ-032 Macro undefined: ovf_cnt port and counter absent; ovf sticky flag only, otherwise identical.

Verification
REQ-033 Reset, then out_en=1 addr=3 data=0x12345678 for one cycle, per_ready=0 -> next cycle per_valid=1, per_addr=3, per_data=0x12345678, count=1.
REQ-034 8 back-to-back writes data=1..8, per_ready=0, then 9th write data=9 -> full=1, count=8, ovf=1, ovf_cnt=1 if enabled; drain yields 1..8 only.
REQ-035 FIFO at count=4, out_en and per_ready both high for 10 cycles -> count stays 4, outputs follow FIFO order across pointer wrap.
REQ-036 per_ready toggled 1/0 each cycle during stream of 20 writes -> no loss, no duplication, order preserved, per_data stable while not accepted.
REQ-037 Full FIFO, out_en=1 and per_ready=1 same cycle -> write dropped, count=7, ovf=1; with ovf_clr=1 same cycle ovf remains 1.
REQ-038 rst pulsed with count=5 -> empty=1, per_valid=0, ovf=0; next write data=0xAA appears at per_data one cycle later.
